cu: RTL and testbench
=====================

Name: cu

Overview:
- Control unit of the multi-cycle CPU.
- Sequences fetch and execute from the instruction register (ir) and status flags.
- Drives every datapath control strobe: register file (two read ports, one write port, auto-increment), IR, status register, MDR, MAR, ALU, and memory read/write.
- Outputs are combinational decodes of the current state plus ir; only the state register is clocked.

Parameters:
- none (widths fixed by cpu_pkg/reg_pkg: 32-bit data, 4-bit reg_e, 4-bit alu_op)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- start  in  1  leave STOP and begin fetching
- ir  in  32  ir_t: [31:28] condition, [27:20] instruction, [19:16] reg_a, [15:12] reg_b, [11:8] reg_c, [15:0] imm16
- status  in  4  status_t {N,Z,C,V} = [3:0]
- mem_rd, mem_wr  out  1  memory read/write strobes (address = B bus)
- a_reg_mask, b_reg_mask  out  32  AND-masks applied to A/B bus IR drivers
- oe_a_reg_file, oe_b_reg_file, ld_reg_file  out  1  register-file enables
- sel_a_reg_file, sel_b_reg_file, sel_in_reg_file  out  4  reg_e selects (PC=15, SP=14)
- count_a_reg_file, count_b_reg_file  out  8  signed auto-increment amount
- pre_count_a_reg_file, pre_count_b_reg_file, post_count_a_reg_file, post_count_b_reg_file  out  1  apply count before/after the access
- oe_a_ir, oe_b_ir, ld_ir  out  1  IR enables
- ld_status  out  1  status register load
- oe_mdr, ld_mdr, oe_mar, ld_mar  out  1  MDR/MAR enables (MAR enables tied 0)
- oe_alu  out  1  ALU result onto result bus
- alu_op  out  4  alu_pkg code

Behaviour:
- Defaults (every state unless overridden):
  - all strobes 0; selects 0; counts 0
  - masks 32'hFFFF_FFFF
- States: STOP, FETCH, EXEC, MEM2.
- Reset: async to STOP; all outputs take their default values.
- STOP:
  - start=1 at clk edge -> FETCH; otherwise stay.
- FETCH:
  - sel_b=PC, oe_b=1, mem_rd=1, ld_ir=1, count_b=1, post_count_b=1
  - -> EXEC
- EXEC decodes ir. Condition codes:
  - 0 NONE: always
  - 1 EQ: Z; 2 NE: !Z
  - 3 LTU: !C; 4 GEU: C; 5 GTU: C&!Z; 6 LEU: !C|Z
  - 7 LTS: N^V; 8 GES: !(N^V); 9 GTS: !Z&!(N^V); 10 LES: Z|(N^V)
  - 11-15 treated as NONE
- Condition false: all strobes 0, -> FETCH.
- Opcodes (EXEC):
  - 0x00 NOP: -> FETCH.
  - 0x01 HALT: -> STOP.
  - 0x10-0x1F ALU reg form, alu_op = instruction[3:0]:
    - sel_a=reg_b, oe_a=1, sel_b=reg_c, oe_b=1
    - oe_alu=1, sel_in=reg_a, ld_reg_file=1, ld_status=1
    - -> FETCH
  - 0x20-0x2F ALU imm form: as reg form, except oe_b_reg_file=0, oe_b_ir=1, b_reg_mask=32'h0000_FFFF.
  - 0x04 LDI:
    - oe_b_ir=1, b_reg_mask=32'h0000_FFFF
    - alu_op=PASSB, oe_alu=1, sel_in=reg_a, ld_reg_file=1
    - -> FETCH
  - 0x02 LD:
    - EXEC: sel_b=reg_b, oe_b=1, mem_rd=1, ld_mdr=1
    - MEM2: oe_mdr=1, sel_in=reg_a, ld_reg_file=1
  - 0x03 ST:
    - EXEC: sel_a=reg_a, oe_a=1, ld_mdr=1
    - MEM2: sel_b=reg_b, oe_b=1, oe_mdr=1, mem_wr=1
  - 0x05 PUSH:
    - EXEC: sel_a=reg_a, oe_a=1, ld_mdr=1
    - MEM2: sel_b=SP, oe_b=1, count_b=8'hFF, pre_count_b=1, oe_mdr=1, mem_wr=1
  - 0x06 POP:
    - EXEC: sel_b=SP, oe_b=1, count_b=1, post_count_b=1, mem_rd=1, ld_mdr=1
    - MEM2: oe_mdr=1, sel_in=reg_a, ld_reg_file=1
  - MEM2 always -> FETCH.
  - Unknown opcode: treated as NOP.
- ALU codes:
  - 0 PASSA, 1 PASSB, 2 AND, 3 OR, 4 XOR, 5 NOT
  - 6 ADD, 7 ADDC, 8 SUB, 9 SUBB
  - 10 SHL, 11 SHR, 12 ASHR, 13 ROL, 14 ROR, 15 NEG
- ALU opcode map: 0x12 = AND, 0x16 = ADD.
- start is ignored outside STOP.
- Reset mid-instruction aborts immediately to STOP.
- oe_a_ir, oe_mar, ld_mar: always 0.

Test Plan:
1. Reset, start sequence: rst=0 then 1, start=0 for 3 clocks -> state stays STOP, all strobes 0. Then start=1, one edge -> FETCH outputs: sel_b=PC, oe_b=1, mem_rd=1, ld_ir=1, count_b=1, post_count_b=1.
2. ALU AND: from FETCH, ir={NONE, 0x12, R0, R1, R2}, edge -> sel_a=R1, oe_a=1, sel_b=R2, oe_b=1, alu_op=AND(2), oe_alu=1, sel_in=R0, ld_reg_file=1, ld_status=1. Next edge -> FETCH.
3. Conditional skip: ir={EQ, 0x16, R3, R4, R5}, status Z=0 -> EXEC strobes all 0, next edge FETCH. Same ir with Z=1 -> ADD executes.
4. LD then ST: LD R1,[R2] -> EXEC: sel_b=R2, mem_rd=1, ld_mdr=1; MEM2: oe_mdr=1, sel_in=R1, ld_reg_file=1. ST R1,[R2] -> MEM2: mem_wr=1, oe_mdr=1, sel_b=R2.
5. PUSH/POP: PUSH R3 -> MEM2: sel_b=SP, count_b=8'hFF, pre_count_b=1, mem_wr=1. POP R3 -> EXEC: sel_b=SP, count_b=1, post_count_b=1, mem_rd=1.
6. LDI, HALT, reset: LDI R7,#0x1234 -> oe_b_ir=1, b_reg_mask=0000FFFF, alu_op=PASSB. HALT -> STOP. rst=0 asserted during MEM2 -> STOP immediately, outputs at defaults.

Source files
------------

// File: rtl/cu.sv
// Control unit for the multi-cycle CPU: a four-state sequencer (STOP/FETCH/EXEC/MEM2)
// whose datapath strobes are combinational decodes of the current state and the IR.
module cu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [3:0]  status,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] a_reg_mask,
    output logic [31:0] b_reg_mask,
    output logic        oe_a_reg_file,
    output logic        oe_b_reg_file,
    output logic        ld_reg_file,
    output logic [3:0]  sel_a_reg_file,
    output logic [3:0]  sel_b_reg_file,
    output logic [3:0]  sel_in_reg_file,
    output logic [7:0]  count_a_reg_file,
    output logic [7:0]  count_b_reg_file,
    output logic        pre_count_a_reg_file,
    output logic        pre_count_b_reg_file,
    output logic        post_count_a_reg_file,
    output logic        post_count_b_reg_file,
    output logic        oe_a_ir,
    output logic        oe_b_ir,
    output logic        ld_ir,
    output logic        ld_status,
    output logic        oe_mdr,
    output logic        ld_mdr,
    output logic        oe_mar,
    output logic        ld_mar,
    output logic        oe_alu,
    output logic [3:0]  alu_op
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_MEM2  = 2'd3;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HALT = 8'h01;
    localparam logic [7:0] OP_LD   = 8'h02;
    localparam logic [7:0] OP_ST   = 8'h03;
    localparam logic [7:0] OP_LDI  = 8'h04;
    localparam logic [7:0] OP_PUSH = 8'h05;
    localparam logic [7:0] OP_POP  = 8'h06;

    localparam logic [3:0] REG_PC     = 4'd15;
    localparam logic [3:0] REG_SP     = 4'd14;
    localparam logic [3:0] ALU_PASSB  = 4'd1;
    localparam logic [31:0] MASK_ALL  = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_IMM  = 32'h0000_FFFF;

    logic [1:0] r_state;
    logic [1:0] w_nextState;
    logic [3:0] w_cond;
    logic [7:0] w_instr;
    logic [3:0] w_regA;
    logic [3:0] w_regB;
    logic [3:0] w_regC;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_condTrue;
    logic       w_unusedIr;

    assign w_cond     = ir[31:28];
    assign w_instr    = ir[27:20];
    assign w_regA     = ir[19:16];
    assign w_regB     = ir[15:12];
    assign w_regC     = ir[11:8];
    assign w_unusedIr = &ir[7:0];
    assign {w_n, w_z, w_c, w_v} = status;

    // Codes 11-15 are reserved and behave like "always".
    always_comb begin
        w_condTrue = 1'b1;
        case (w_cond)
            4'd1:    w_condTrue = w_z;
            4'd2:    w_condTrue = !w_z;
            4'd3:    w_condTrue = !w_c;
            4'd4:    w_condTrue = w_c;
            4'd5:    w_condTrue = w_c && !w_z;
            4'd6:    w_condTrue = !w_c || w_z;
            4'd7:    w_condTrue = w_n ^ w_v;
            4'd8:    w_condTrue = !(w_n ^ w_v);
            4'd9:    w_condTrue = !w_z && !(w_n ^ w_v);
            4'd10:   w_condTrue = w_z || (w_n ^ w_v);
            default: w_condTrue = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_STOP;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState           = r_state;
        mem_rd                = 1'b0;
        mem_wr                = 1'b0;
        a_reg_mask            = MASK_ALL;
        b_reg_mask            = MASK_ALL;
        oe_a_reg_file         = 1'b0;
        oe_b_reg_file         = 1'b0;
        ld_reg_file           = 1'b0;
        sel_a_reg_file        = 4'd0;
        sel_b_reg_file        = 4'd0;
        sel_in_reg_file       = 4'd0;
        count_a_reg_file      = 8'd0;
        count_b_reg_file      = 8'd0;
        pre_count_a_reg_file  = 1'b0;
        pre_count_b_reg_file  = 1'b0;
        post_count_a_reg_file = 1'b0;
        post_count_b_reg_file = 1'b0;
        oe_a_ir               = 1'b0;
        oe_b_ir               = 1'b0;
        ld_ir                 = 1'b0;
        ld_status             = 1'b0;
        oe_mdr                = 1'b0;
        ld_mdr                = 1'b0;
        oe_mar                = 1'b0;
        ld_mar                = 1'b0;
        oe_alu                = 1'b0;
        alu_op                = 4'd0;

        case (r_state)
            ST_STOP: begin
                if (start) w_nextState = ST_FETCH;
            end
            ST_FETCH: begin
                sel_b_reg_file        = REG_PC;
                oe_b_reg_file         = 1'b1;
                mem_rd                = 1'b1;
                ld_ir                 = 1'b1;
                count_b_reg_file      = 8'd1;
                post_count_b_reg_file = 1'b1;
                w_nextState           = ST_EXEC;
            end
            ST_EXEC: begin
                w_nextState = ST_FETCH;
                if (w_condTrue) begin
                    // The register and immediate ALU forms differ only in the B-bus source.
                    if (w_instr[7:4] == 4'h1 || w_instr[7:4] == 4'h2) begin
                        alu_op          = w_instr[3:0];
                        sel_a_reg_file  = w_regB;
                        oe_a_reg_file   = 1'b1;
                        sel_b_reg_file  = w_regC;
                        oe_alu          = 1'b1;
                        sel_in_reg_file = w_regA;
                        ld_reg_file     = 1'b1;
                        ld_status       = 1'b1;
                        if (w_instr[7:4] == 4'h1) begin
                            oe_b_reg_file = 1'b1;
                        end else begin
                            oe_b_ir    = 1'b1;
                            b_reg_mask = MASK_IMM;
                        end
                    end else begin
                        case (w_instr)
                            OP_HALT: w_nextState = ST_STOP;
                            OP_LDI: begin
                                oe_b_ir         = 1'b1;
                                b_reg_mask      = MASK_IMM;
                                alu_op          = ALU_PASSB;
                                oe_alu          = 1'b1;
                                sel_in_reg_file = w_regA;
                                ld_reg_file     = 1'b1;
                            end
                            OP_LD: begin
                                sel_b_reg_file = w_regB;
                                oe_b_reg_file  = 1'b1;
                                mem_rd         = 1'b1;
                                ld_mdr         = 1'b1;
                                w_nextState    = ST_MEM2;
                            end
                            OP_ST, OP_PUSH: begin
                                sel_a_reg_file = w_regA;
                                oe_a_reg_file  = 1'b1;
                                ld_mdr         = 1'b1;
                                w_nextState    = ST_MEM2;
                            end
                            OP_POP: begin
                                sel_b_reg_file        = REG_SP;
                                oe_b_reg_file         = 1'b1;
                                count_b_reg_file      = 8'd1;
                                post_count_b_reg_file = 1'b1;
                                mem_rd                = 1'b1;
                                ld_mdr                = 1'b1;
                                w_nextState           = ST_MEM2;
                            end
                            OP_NOP:  w_nextState = ST_FETCH;
                            default: w_nextState = ST_FETCH;
                        endcase
                    end
                end
            end
            ST_MEM2: begin
                w_nextState = ST_FETCH;
                case (w_instr)
                    OP_LD, OP_POP: begin
                        oe_mdr          = 1'b1;
                        sel_in_reg_file = w_regA;
                        ld_reg_file     = 1'b1;
                    end
                    OP_ST: begin
                        sel_b_reg_file = w_regB;
                        oe_b_reg_file  = 1'b1;
                        oe_mdr         = 1'b1;
                        mem_wr         = 1'b1;
                    end
                    OP_PUSH: begin
                        sel_b_reg_file       = REG_SP;
                        oe_b_reg_file        = 1'b1;
                        count_b_reg_file     = 8'hFF;
                        pre_count_b_reg_file = 1'b1;
                        oe_mdr               = 1'b1;
                        mem_wr               = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: w_nextState = ST_STOP;
        endcase
    end

endmodule

// File: tb/tb_cu.sv
// Directed bench for cu: expected control words are queued with each step and
// popped for comparison one clock later (or immediately for async reset checks).
module tb_cu;

    typedef struct packed {
        logic        memRd;
        logic        memWr;
        logic [31:0] aMask;
        logic [31:0] bMask;
        logic        oeA;
        logic        oeB;
        logic        ldRf;
        logic [3:0]  selA;
        logic [3:0]  selB;
        logic [3:0]  selIn;
        logic [7:0]  cntA;
        logic [7:0]  cntB;
        logic        preA;
        logic        preB;
        logic        postA;
        logic        postB;
        logic        oeAIr;
        logic        oeBIr;
        logic        ldIr;
        logic        ldStatus;
        logic        oeMdr;
        logic        ldMdr;
        logic        oeMar;
        logic        ldMar;
        logic        oeAlu;
        logic [3:0]  aluOp;
    } ctl_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] ir;
    logic [3:0]  status;
    ctl_t        obs;

    ctl_t        expQ[$];
    string       tagQ[$];
    int          passCount = 0;
    int          totalCount = 0;

    cu dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .ir                    (ir),
        .status                (status),
        .mem_rd                (obs.memRd),
        .mem_wr                (obs.memWr),
        .a_reg_mask            (obs.aMask),
        .b_reg_mask            (obs.bMask),
        .oe_a_reg_file         (obs.oeA),
        .oe_b_reg_file         (obs.oeB),
        .ld_reg_file           (obs.ldRf),
        .sel_a_reg_file        (obs.selA),
        .sel_b_reg_file        (obs.selB),
        .sel_in_reg_file       (obs.selIn),
        .count_a_reg_file      (obs.cntA),
        .count_b_reg_file      (obs.cntB),
        .pre_count_a_reg_file  (obs.preA),
        .pre_count_b_reg_file  (obs.preB),
        .post_count_a_reg_file (obs.postA),
        .post_count_b_reg_file (obs.postB),
        .oe_a_ir               (obs.oeAIr),
        .oe_b_ir               (obs.oeBIr),
        .ld_ir                 (obs.ldIr),
        .ld_status             (obs.ldStatus),
        .oe_mdr                (obs.oeMdr),
        .ld_mdr                (obs.ldMdr),
        .oe_mar                (obs.oeMar),
        .ld_mar                (obs.ldMar),
        .oe_alu                (obs.oeAlu),
        .alu_op                (obs.aluOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t dflt();
        ctl_t c;
        c       = '0;
        c.aMask = 32'hFFFF_FFFF;
        c.bMask = 32'hFFFF_FFFF;
        return c;
    endfunction

    function automatic ctl_t fetchWord();
        ctl_t c;
        c       = dflt();
        c.selB  = 4'd15;
        c.oeB   = 1'b1;
        c.memRd = 1'b1;
        c.ldIr  = 1'b1;
        c.cntB  = 8'd1;
        c.postB = 1'b1;
        return c;
    endfunction

    function automatic logic [31:0] mkIr(input logic [3:0] cond, input logic [7:0] op,
                                         input logic [3:0] ra, input logic [3:0] rb,
                                         input logic [3:0] rc);
        return {cond, op, ra, rb, rc, 8'h00};
    endfunction

    task automatic applyStimulus(input ctl_t exp, input string tag);
        expQ.push_back(exp);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        ctl_t  exp;
        string tag;
        if (expQ.size() == 0) begin
            totalCount++;
            $error("[TB] FAIL scoreboard_empty: observed=%h required=<queued entry>", obs);
        end else begin
            exp = expQ.pop_front();
            tag = tagQ.pop_front();
            totalCount++;
            assert (obs === exp) passCount++;
            else $error("[TB] FAIL %s: observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected word, advance one edge, compare.
    task automatic stepCheck(input ctl_t exp, input string tag);
        applyStimulus(exp, tag);
        tick();
        checkOutput();
    endtask

    initial begin
        ctl_t e;
        rst    = 1'b0;
        start  = 1'b0;
        ir     = 32'h0;
        status = 4'h0;
        #1;
        applyStimulus(dflt(), "reset_defaults");
        checkOutput();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 3; i++) stepCheck(dflt(), "stop_hold");

        start = 1'b1;
        stepCheck(fetchWord(), "fetch_after_start");
        start = 1'b0;

        ir = mkIr(4'd0, 8'h12, 4'd0, 4'd1, 4'd2);
        e = dflt();
        e.selA = 4'd1; e.oeA = 1'b1; e.selB = 4'd2; e.oeB = 1'b1;
        e.aluOp = 4'd2; e.oeAlu = 1'b1; e.selIn = 4'd0; e.ldRf = 1'b1; e.ldStatus = 1'b1;
        stepCheck(e, "alu_and_exec");
        stepCheck(fetchWord(), "alu_and_refetch");

        ir = mkIr(4'd1, 8'h16, 4'd3, 4'd4, 4'd5);
        status = 4'b0000;
        stepCheck(dflt(), "eq_skip_exec");
        stepCheck(fetchWord(), "eq_skip_refetch");
        status = 4'b0100;
        e = dflt();
        e.selA = 4'd4; e.oeA = 1'b1; e.selB = 4'd5; e.oeB = 1'b1;
        e.aluOp = 4'd6; e.oeAlu = 1'b1; e.selIn = 4'd3; e.ldRf = 1'b1; e.ldStatus = 1'b1;
        stepCheck(e, "eq_taken_add");
        stepCheck(fetchWord(), "eq_taken_refetch");

        ir = mkIr(4'd7, 8'h16, 4'd3, 4'd4, 4'd5);
        status = 4'b1001;
        stepCheck(dflt(), "lts_skip_nv_equal");
        stepCheck(fetchWord(), "lts_skip_refetch");

        ir = mkIr(4'd12, 8'h26, 4'd6, 4'd8, 4'd9);
        status = 4'b0000;
        e = dflt();
        e.selA = 4'd8; e.oeA = 1'b1; e.selB = 4'd9; e.oeBIr = 1'b1; e.bMask = 32'h0000_FFFF;
        e.aluOp = 4'd6; e.oeAlu = 1'b1; e.selIn = 4'd6; e.ldRf = 1'b1; e.ldStatus = 1'b1;
        stepCheck(e, "alu_imm_cond12");
        stepCheck(fetchWord(), "alu_imm_refetch");

        ir = mkIr(4'd0, 8'h02, 4'd1, 4'd2, 4'd0);
        e = dflt();
        e.selB = 4'd2; e.oeB = 1'b1; e.memRd = 1'b1; e.ldMdr = 1'b1;
        stepCheck(e, "ld_exec");
        e = dflt();
        e.oeMdr = 1'b1; e.selIn = 4'd1; e.ldRf = 1'b1;
        stepCheck(e, "ld_mem2");
        stepCheck(fetchWord(), "ld_refetch");

        ir = mkIr(4'd0, 8'h03, 4'd1, 4'd2, 4'd0);
        e = dflt();
        e.selA = 4'd1; e.oeA = 1'b1; e.ldMdr = 1'b1;
        stepCheck(e, "st_exec");
        e = dflt();
        e.selB = 4'd2; e.oeB = 1'b1; e.oeMdr = 1'b1; e.memWr = 1'b1;
        stepCheck(e, "st_mem2");
        stepCheck(fetchWord(), "st_refetch");

        ir = mkIr(4'd0, 8'h05, 4'd3, 4'd0, 4'd0);
        e = dflt();
        e.selA = 4'd3; e.oeA = 1'b1; e.ldMdr = 1'b1;
        stepCheck(e, "push_exec");
        e = dflt();
        e.selB = 4'd14; e.oeB = 1'b1; e.cntB = 8'hFF; e.preB = 1'b1; e.oeMdr = 1'b1; e.memWr = 1'b1;
        stepCheck(e, "push_mem2");
        stepCheck(fetchWord(), "push_refetch");

        ir = mkIr(4'd0, 8'h06, 4'd3, 4'd0, 4'd0);
        e = dflt();
        e.selB = 4'd14; e.oeB = 1'b1; e.cntB = 8'd1; e.postB = 1'b1; e.memRd = 1'b1; e.ldMdr = 1'b1;
        stepCheck(e, "pop_exec");
        e = dflt();
        e.oeMdr = 1'b1; e.selIn = 4'd3; e.ldRf = 1'b1;
        stepCheck(e, "pop_mem2");
        stepCheck(fetchWord(), "pop_refetch");

        ir = {4'd0, 8'h04, 4'd7, 16'h1234};
        e = dflt();
        e.oeBIr = 1'b1; e.bMask = 32'h0000_FFFF; e.aluOp = 4'd1; e.oeAlu = 1'b1;
        e.selIn = 4'd7; e.ldRf = 1'b1;
        stepCheck(e, "ldi_exec");
        stepCheck(fetchWord(), "ldi_refetch");

        ir = mkIr(4'd0, 8'h7E, 4'd1, 4'd1, 4'd1);
        stepCheck(dflt(), "unknown_as_nop");
        stepCheck(fetchWord(), "unknown_refetch");

        ir = mkIr(4'd0, 8'h01, 4'd0, 4'd0, 4'd0);
        stepCheck(dflt(), "halt_exec");
        stepCheck(dflt(), "halt_stop");
        stepCheck(dflt(), "halt_stop_hold");

        start = 1'b1;
        stepCheck(fetchWord(), "restart_fetch");
        start = 1'b0;
        ir = mkIr(4'd0, 8'h02, 4'd1, 4'd2, 4'd0);
        e = dflt();
        e.selB = 4'd2; e.oeB = 1'b1; e.memRd = 1'b1; e.ldMdr = 1'b1;
        stepCheck(e, "abort_ld_exec");
        e = dflt();
        e.oeMdr = 1'b1; e.selIn = 4'd1; e.ldRf = 1'b1;
        stepCheck(e, "abort_ld_mem2");
        #2;
        rst = 1'b0;
        #1;
        applyStimulus(dflt(), "async_abort_defaults");
        checkOutput();
        tick();
        rst = 1'b1;
        stepCheck(dflt(), "after_abort_stop");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
